// File: rtl/lattice_stream_reader.sv
// Streams one LBM lattice frame from a banked BRAM onto an AXI4-Stream master, one node per beat.
// Optional SOF_TUSER_EN adds m_axis_tuser marking the node-0 beat.
module lattice_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_DIR       = 9,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 1,
  localparam int W            = NUM_DIR*DATA_WIDTH,
  localparam int K            = W/8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_ready,
  output logic                     bram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] bram_rd_addr,
  input  logic [W-1:0]             bram_rd_data,
  output logic [W-1:0]             m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [K-1:0]             m_axis_tkeep,
`ifdef SOF_TUSER_EN
  output logic                     m_axis_tuser,
`endif
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int FD = READ_LATENCY + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD+1) + 1;
`ifdef SOF_TUSER_EN
  localparam int FW = 2;
`else
  localparam int FW = 1;
`endif
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     done_q, ovr_q;

  // Delay line tags each read; flag bit 0 = last node, bit 1 = first node.
  logic [READ_LATENCY-1:0]          vld_pipe_q;
  logic [READ_LATENCY-1:0][FW-1:0]  flg_pipe_q;
  logic [FW-1:0]                    flg_in;

  logic [FD-1:0][FW+W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fcnt_q, fcnt_d, infl;
  logic                    credit, push, pop, head_last;

  always_comb begin
    infl = '0;
    for (int i = 0; i < READ_LATENCY; i++) infl = infl + CW'(vld_pipe_q[i]);
  end

  assign credit = (infl + fcnt_q) < CW'(FD);

  always_comb begin
    flg_in    = '0;
    flg_in[0] = (cnt_q == LAST_ADDR);
`ifdef SOF_TUSER_EN
    flg_in[1] = (cnt_q == '0);
`endif
  end

  assign m_axis_tvalid = (fcnt_q != '0);
  assign head_last     = mem_q[rd_ptr_q][W];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push          = vld_pipe_q[READ_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bram_rd_en = 1'b0;
    case (state_q)
      IDLE: if (frame_ready) begin
        state_d = ISSUE;
        cnt_d   = '0;
      end
      ISSUE: if (credit) begin
        bram_rd_en = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop) fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      vld_pipe_q <= '0;
      flg_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= pop && head_last;
      if (frame_ready && state_q != IDLE) ovr_q <= 1'b1;
      vld_pipe_q[0] <= bram_rd_en;
      flg_pipe_q[0] <= flg_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        flg_pipe_q[i] <= flg_pipe_q[i-1];
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FD-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FD-1)) ? '0 : rd_ptr_q + 1'b1;
      fcnt_q        <= fcnt_d;
    end
  end

  // Payload storage needs no reset; validity lives in fcnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {flg_pipe_q[READ_LATENCY-1], bram_rd_data};
  end

  assign bram_rd_addr = cnt_q;
  assign m_axis_tdata = mem_q[rd_ptr_q][W-1:0];
  assign m_axis_tlast = m_axis_tvalid && head_last;
  assign m_axis_tkeep = m_axis_tvalid ? {K{1'b1}} : {K{1'b0}};
`ifdef SOF_TUSER_EN
  assign m_axis_tuser = m_axis_tvalid && mem_q[rd_ptr_q][W+1];
`endif
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_lattice_stream_reader.sv
module tb_lattice_stream_reader;
  localparam int DW = 16, ND = 9, DEPTH = 8, AW = 12;
  localparam int W = DW*ND, K = W/8;

  logic clk, rst_n;
  logic [1:0] fr, tr, rd_en, tvalid, tlast, busy, done, ovr, tuser;
  logic [AW-1:0] addr [2];
  logic [W-1:0]  rdata [2];
  logic [W-1:0]  tdata [2];
  logic [K-1:0]  tkeep [2];
  logic [W-1:0]  m1, m2a, m2b;

  int n_chk, n_fail;
  int beats_tot, last_tot, sof_tot;

  task automatic chk(input string tag, input logic [W-1:0] o_v, input logic [W-1:0] e_v);
    n_chk++;
    if (o_v !== e_v) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o_v, e_v);
    end
  endtask

  lattice_stream_reader #(.DATA_WIDTH(DW), .NUM_DIR(ND), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .READ_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .frame_ready(fr[0]), .bram_rd_en(rd_en[0]), .bram_rd_addr(addr[0]),
    .bram_rd_data(rdata[0]), .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tr[0]),
    .m_axis_tlast(tlast[0]), .m_axis_tkeep(tkeep[0]),
`ifdef SOF_TUSER_EN
    .m_axis_tuser(tuser[0]),
`endif
    .busy(busy[0]), .frame_done(done[0]), .overrun(ovr[0]));

  lattice_stream_reader #(.DATA_WIDTH(DW), .NUM_DIR(ND), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .READ_LATENCY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_ready(fr[1]), .bram_rd_en(rd_en[1]), .bram_rd_addr(addr[1]),
    .bram_rd_data(rdata[1]), .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tr[1]),
    .m_axis_tlast(tlast[1]), .m_axis_tkeep(tkeep[1]),
`ifdef SOF_TUSER_EN
    .m_axis_tuser(tuser[1]),
`endif
    .busy(busy[1]), .frame_done(done[1]), .overrun(ovr[1]));

`ifndef SOF_TUSER_EN
  assign tuser = 2'b00;
`endif

  function automatic logic [W-1:0] word(input int a);
    logic [W-1:0] w;
    w = '0;
    for (int d = 0; d < ND; d++) w[(ND-1-d)*DW +: DW] = DW'((a << 8) | (d << 4) | 3);
    return w;
  endfunction

  always @(posedge clk) begin
    if (rd_en[0]) m1 <= word(int'(addr[0]));
    if (rd_en[1]) m2a <= word(int'(addr[1]));
    m2b <= m2a;
  end
  assign rdata[0] = m1;
  assign rdata[1] = m2b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic stream(input int s, input int mode, input bit pulse, input int ovr_at,
                        input int rst_at, input bit chain);
    int issued, popped, cyc, lat, lastc, fd, rl, k;
    bit stall_p, ovr_done;
    logic [W-1:0] pdat;
    logic plast;
    fd = (s == 0) ? 3 : 4;
    rl = s + 1;
    issued = 0; popped = 0; cyc = 0; lat = -1; lastc = -1;
    stall_p = 0; ovr_done = 0; pdat = '0; plast = 0;
    if (pulse) begin fr[s] = 1'b1; tick; fr[s] = 1'b0; cyc = 1; end
    while (popped < DEPTH && cyc < 300) begin
      if (rst_at == popped && tvalid[s]) begin
        rst_n = 1'b0; tick; rst_n = 1'b1;
        chk("rst_tvalid", tvalid[s], 1'b0);
        chk("rst_busy", busy[s], 1'b0);
        chk("rst_rd_en", rd_en[s], 1'b0);
        chk("rst_addr", addr[s], 12'd0);
        chk("rst_tlast", tlast[s], 1'b0);
        chk("rst_tkeep", tkeep[s], 18'd0);
        chk("rst_done", done[s], 1'b0);
        chk("rst_overrun", ovr[s], 1'b0);
        return;
      end
      k = cyc % 4;
      case (mode)
        1:       tr[s] = (k == 0 || k == 3);
        2:       tr[s] = (cyc >= 20);
        default: tr[s] = 1'b1;
      endcase
      if (mode == 2 && cyc == 20) begin
        chk("stall_reads", issued, fd);
        chk("stall_rd_en", rd_en[s], 1'b0);
      end
      if (ovr_at == popped && !ovr_done) begin fr[s] = 1'b1; ovr_done = 1; end
      else fr[s] = 1'b0;
      if (rd_en[s]) begin
        chk("credit", (issued - popped) < fd, 1'b1);
        chk("rd_addr", int'(addr[s]), issued);
        issued++;
      end
      if (tvalid[s] && stall_p) begin
        chk("hold_tdata", tdata[s], pdat);
        chk("hold_tlast", tlast[s], plast);
      end
      if (tvalid[s] && tr[s]) begin
        if (lat < 0) lat = cyc;
        lastc = cyc;
        chk("tdata", tdata[s], word(popped));
        chk("tlast", tlast[s], (popped == DEPTH-1));
        chk("tkeep", tkeep[s], {K{1'b1}});
`ifdef SOF_TUSER_EN
        chk("tuser", tuser[s], (popped == 0));
`endif
        beats_tot++;
        if (tlast[s]) last_tot++;
        if (tuser[s]) sof_tot++;
        popped++;
        stall_p = 0;
      end else begin
        stall_p = tvalid[s]; pdat = tdata[s]; plast = tlast[s];
      end
      tick; cyc++;
    end
    fr[s] = 1'b0;
    chk("beats", popped, DEPTH);
    chk("reads", issued, DEPTH);
    if (pulse && mode == 0) begin
      chk("first_latency", lat, 2 + rl);
      chk("last_beat_cycle", lastc, DEPTH + rl + 1);
    end
    chk("done_pulse", done[s], 1'b1);
    chk("done_busy", busy[s], 1'b0);
    chk("done_tvalid", tvalid[s], 1'b0);
    if (chain) begin
      fr[s] = 1'b1; tick; fr[s] = 1'b0;
      chk("done_clear", done[s], 1'b0);
      chk("chain_busy", busy[s], 1'b1);
    end else begin
      tick;
      chk("done_clear", done[s], 1'b0);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; beats_tot = 0; last_tot = 0; sof_tot = 0;
    rst_n = 1'b0; fr = '0; tr = '0;
    repeat (3) tick;
    for (int s = 0; s < 2; s++) begin
      chk("reset_rd_en", rd_en[s], 1'b0);
      chk("reset_addr", addr[s], 12'd0);
      chk("reset_tvalid", tvalid[s], 1'b0);
      chk("reset_tlast", tlast[s], 1'b0);
      chk("reset_tkeep", tkeep[s], 18'd0);
      chk("reset_busy", busy[s], 1'b0);
      chk("reset_done", done[s], 1'b0);
      chk("reset_overrun", ovr[s], 1'b0);
      chk("reset_tuser", tuser[s], 1'b0);
    end
    rst_n = 1'b1;
    tick;

    stream(0, 0, 1'b1, -1, -1, 1'b0);
    stream(1, 1, 1'b1, -1, -1, 1'b0);
    stream(1, 2, 1'b1, -1, -1, 1'b0);

    stream(0, 0, 1'b1, 3, -1, 1'b0);
    chk("overrun_set", ovr[0], 1'b1);
    repeat (10) begin
      chk("no_second_frame", tvalid[0] | rd_en[0] | busy[0], 1'b0);
      tick;
    end
    chk("overrun_sticky", ovr[0], 1'b1);

    stream(0, 0, 1'b1, -1, 4, 1'b0);
    tick;
    stream(0, 0, 1'b1, -1, -1, 1'b0);

    beats_tot = 0; last_tot = 0; sof_tot = 0;
    stream(0, 0, 1'b1, -1, -1, 1'b1);
    stream(0, 0, 1'b0, -1, -1, 1'b0);
    chk("b2b_beats", beats_tot, 2*DEPTH);
    chk("b2b_tlast", last_tot, 2);
`ifdef SOF_TUSER_EN
    chk("b2b_tuser", sof_tot, 2);
`else
    chk("b2b_tuser", sof_tot, 0);
`endif
    chk("b2b_overrun", ovr[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lattice_stream_reader.md
Name: lattice_stream_reader

Overview:
- Streams one full lattice frame of LBM distribution data from a banked BRAM onto an AXI4-Stream master, one lattice node per beat.
- Each beat carries all NUM_DIR direction values for one node.
- Parametrised successor to the fixed 9x16-bit, 2500-node BRAM reader: generalised in direction count, width, depth and BRAM read latency.
- Adds full tready backpressure via a credit-controlled output FIFO, frame completion and overrun status, and an optional start-of-frame tuser.
- Sits between the collision/streaming core's result BRAM and the DMA/AXI-Stream interconnect.

Parameters:
- DATA_WIDTH, 16: bits per direction value; must be a multiple of 8.
- NUM_DIR, 9: directions per node (D2Q9 = 9).
- DEPTH, 2500: nodes per frame; must be >= 2.
- ADDRESS_WIDTH, 12: BRAM address width; 2^ADDRESS_WIDTH >= DEPTH.
- READ_LATENCY, 1: BRAM read latency in cycles; legal values are 1 and 2.
- Derived W = NUM_DIR*DATA_WIDTH (tdata width), K = W/8 (tkeep width), FIFO_DEPTH = READ_LATENCY+2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- frame_ready  in  1  single-cycle pulse: the BRAM holds a complete new frame.
- bram_rd_en  out  1  BRAM read enable.
- bram_rd_addr  out  ADDRESS_WIDTH  BRAM read address.
- bram_rd_data  in  W  BRAM read data, valid READ_LATENCY cycles after bram_rd_en.
- m_axis_tdata  out  W  node data, passed through bit-for-bit from bram_rd_data (direction 0 in the MSBs).
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  high on the beat for node DEPTH-1.
- m_axis_tkeep  out  K  all ones whenever tvalid is high, zero otherwise.
- busy  out  1  high from frame acceptance until the last beat is accepted.
- frame_done  out  1  one-cycle pulse on the cycle after the tlast handshake.
- overrun  out  1  sticky error: frame_ready arrived while busy.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, address counter 0, FIFO empty, in-flight reads discarded.
- Reset values: bram_rd_en=0, bram_rd_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, busy=0, frame_done=0, overrun=0.
- Reset mid-frame aborts immediately; no tlast is emitted for the aborted frame.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - frame_ready=1 -> ISSUE, busy=1 the next cycle, address counter=0.
  - frame_ready=0 -> stay in IDLE.
- ISSUE:
  - Assert bram_rd_en with bram_rd_addr = counter only when credit is available: in_flight + fifo_count < FIFO_DEPTH, evaluated combinationally on the current cycle.
  - Counter increments on each issued read.
  - After issuing address DEPTH-1 -> DRAIN, counter wraps to 0.
- DRAIN: no reads issued; when the FIFO is empty and in_flight=0 after the tlast handshake -> IDLE, busy=0, frame_done=1 for one cycle.
- Read return: a delay line of length READ_LATENCY tags each read, together with an is_last flag (address == DEPTH-1). Returned data and flag are written into the FIFO.
- The credit rule guarantees the FIFO never overflows; no data path may drop a word.
- Output:
  - FIFO head drives tdata/tlast; tvalid = FIFO non-empty.
  - A pop occurs only on tvalid && tready.
  - tdata, tlast and tkeep are held stable while tvalid=1 and tready=0.
- Minimum latency from frame_ready to first tvalid: 2+READ_LATENCY cycles (1 for acceptance, 1 for issue, READ_LATENCY for the read).
- Throughput: with tready held at 1, one beat per cycle sustained. DEPTH beats complete in DEPTH+READ_LATENCY+2 cycles from frame_ready.
- The FIFO supports a push and a pop in the same cycle; occupancy is unchanged.
- frame_ready while busy: ignored for streaming, sets overrun=1. overrun clears only on reset.
- frame_ready in the same cycle as the frame_done pulse: accepted, because busy is already 0 in that cycle.
- Counter and address arithmetic is unsigned ADDRESS_WIDTH. Addresses never exceed DEPTH-1.

Optional Feature:
- Macro SOF_TUSER_EN.
- When defined: adds output m_axis_tuser (1 bit).
  - High on the beat for node 0 only; zero at reset and when tvalid=0.
  - The flag is carried through the delay line and FIFO alongside is_last.
- When undefined: the port does not exist and no extra storage is built. All other behaviour is identical.

Test Plan:
- DEPTH=8, READ_LATENCY=1, tready=1, one frame_ready pulse -> 8 consecutive beats carrying BRAM words 0..7; tlast only on beat 7; tkeep=18'h3FFFF; frame_done pulses one cycle after beat 7; first tvalid 3 cycles after frame_ready.
- DEPTH=8, READ_LATENCY=2, tready toggling 1,0,0,1 repeating -> all 8 words delivered in order with no loss or duplicates; tdata stable during stalls; bram_rd_en never asserted when in_flight+fifo_count=4.
- tready=0 for 20 cycles after frame start -> exactly FIFO_DEPTH reads issued, then bram_rd_en=0; stream resumes correctly when tready returns to 1.
- Second frame_ready at beat 3 of a frame -> overrun=1 and stays 1; the current frame completes with exactly 8 beats; no second frame starts.
- rst_n=0 for one cycle at beat 4 -> next cycle tvalid=0, busy=0, all outputs at reset values; a fresh frame_ready then yields 8 clean beats starting at address 0.
- SOF_TUSER_EN defined, two back-to-back frames (second frame_ready on the frame_done cycle) -> tuser=1 on beat 0 of each frame only; 16 beats total; two tlast beats.
